// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the ShiftBuffer frame sequencer.
package shift_ctrl_pkg;

  localparam int unsigned WORD_WIDTH = 17;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    CAPTURE,
    OUT,
    DONE,
    ABORT
  } ctrlState_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_timeout_counter.sv
// Idle-cycle counter for the SHIFT state; flags the cycle whose increment reaches TIMEOUT_CYCLES.
module shift_timeout_counter
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic Core_clk,
  input  logic Core_reset,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Saturates at the terminal value so a held enable cannot wrap.
  always_ff @(posedge Core_clk) begin
    if (Core_reset || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(TIMEOUT_CYCLES))) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire_c = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/shift_buffer_ctrl.sv
// Frame sequencer for the 17-bit ShiftBuffer: clears it, gates serial bits in,
// drains each full word to an indexed output stream, and aborts on stall.
module shift_buffer_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_WORDS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  // Derived from FRAME_WORDS; not meant to be overridden.
  parameter int unsigned IDX_W          = (clog2(FRAME_WORDS) < 1) ? 1 : clog2(FRAME_WORDS)
) (
  input  logic                  Core_clk,
  input  logic                  Core_reset,
  input  logic                  io_start,
  input  logic                  io_abort,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_error,
  input  logic                  io_serIn_valid,
  output logic                  io_serIn_ready,
  input  logic                  io_serIn_payload,
  output logic                  io_bufIn_valid,
  input  logic                  io_bufIn_ready,
  output logic                  io_bufIn_payload,
  input  logic                  io_bufOut_valid,
  output logic                  io_bufOut_ready,
  input  logic [WORD_WIDTH-1:0] io_bufOut_payload,
  output logic                  io_bufReset,
  output logic                  io_wordOut_valid,
  input  logic                  io_wordOut_ready,
  output logic [WORD_WIDTH-1:0] io_wordOut_payload,
  output logic [IDX_W-1:0]      io_wordOut_index,
  output logic                  io_wordOut_last
);

  ctrlState_t            state;
  logic [IDX_W-1:0]      wordCnt;
  logic [WORD_WIDTH-1:0] wordReg;
  logic                  errorReg;
  logic                  bitAccept_c;
  logic                  timeoutHit_c;
  logic                  lastWord_c;

  assign bitAccept_c = (state == SHIFT) && io_serIn_valid && io_bufIn_ready;
  assign lastWord_c  = (wordCnt == IDX_W'(FRAME_WORDS - 1));

  shift_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) uTimeout (
    .Core_clk   (Core_clk),
    .Core_reset (Core_reset),
    .clear      ((state == CLEAR) || bitAccept_c),
    .enable     ((state == SHIFT) && !bitAccept_c),
    .expire_c   (timeoutHit_c)
  );

  // Sequencer; abort outranks every other transition outside IDLE.
  always_ff @(posedge Core_clk) begin
    if (Core_reset) begin
      state    <= IDLE;
      wordCnt  <= '0;
      wordReg  <= '0;
      errorReg <= 1'b0;
    end else if (io_abort && (state != IDLE)) begin
      state    <= ABORT;
      errorReg <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (io_start) begin
            errorReg <= 1'b0;
            wordCnt  <= '0;
            state    <= CLEAR;
          end
        end
        CLEAR: state <= SHIFT;
        SHIFT: begin
          // A completed word wins over a timeout landing on the same cycle.
          if (io_bufOut_valid) begin
            state <= CAPTURE;
          end else if (timeoutHit_c) begin
            state    <= ABORT;
            errorReg <= 1'b1;
          end
        end
        CAPTURE: begin
          wordReg <= io_bufOut_payload;
          state   <= OUT;
        end
        OUT: begin
          if (io_wordOut_ready) begin
            if (lastWord_c) begin
              state <= DONE;
            end else begin
              wordCnt <= wordCnt + IDX_W'(1);
              state   <= CLEAR;
            end
          end
        end
        DONE:    state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign io_busy            = (state != IDLE);
  assign io_done            = (state == DONE);
  assign io_error           = errorReg;
  assign io_serIn_ready     = (state == SHIFT) && io_bufIn_ready;
  assign io_bufIn_valid     = (state == SHIFT) && io_serIn_valid;
  assign io_bufIn_payload   = io_serIn_payload;
  assign io_bufOut_ready    = (state == CAPTURE);
  assign io_bufReset        = Core_reset || (state == CLEAR) || (state == ABORT);
  assign io_wordOut_valid   = (state == OUT);
  assign io_wordOut_payload = wordReg;
  assign io_wordOut_index   = wordCnt;
  assign io_wordOut_last    = (state == OUT) && lastWord_c;

endmodule

// File: tb/tb_shift_buffer_ctrl.sv
// Bench for shift_buffer_ctrl: each controller is paired with a behavioural ShiftBuffer,
// and accepted serial bits are re-assembled into expected words independently of the DUT.
module tb_shift_buffer_ctrl;

  localparam int unsigned WW   = 17;
  localparam int unsigned FW_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Instance A: FRAME_WORDS=4
  logic startA = 1'b0, abortA = 1'b0, busyA, doneA, errorA;
  logic serValidA = 1'b0, serReadyA, serBitA = 1'b0;
  logic bufInValidA, bufInReadyA, bufInBitA, bufOutValidA, bufOutReadyA, bufResetA;
  logic [WW-1:0] bufOutWordA, woWordA;
  logic woValidA, woReadyA = 1'b1, woLastA;
  logic [1:0] woIdxA;

  // Instance B: FRAME_WORDS=1, downstream always ready
  logic startB = 1'b0, abortB = 1'b0, busyB, doneB, errorB;
  logic serValidB = 1'b0, serReadyB, serBitB = 1'b0;
  logic bufInValidB, bufInReadyB, bufInBitB, bufOutValidB, bufOutReadyB, bufResetB;
  logic [WW-1:0] bufOutWordB, woWordB;
  logic woValidB, woLastB;
  logic woReadyB = 1'b1;
  logic [0:0] woIdxB;

  shift_buffer_ctrl #(.FRAME_WORDS(4), .TIMEOUT_CYCLES(255)) dutA (
    .Core_clk(clk), .Core_reset(rst), .io_start(startA), .io_abort(abortA),
    .io_busy(busyA), .io_done(doneA), .io_error(errorA),
    .io_serIn_valid(serValidA), .io_serIn_ready(serReadyA), .io_serIn_payload(serBitA),
    .io_bufIn_valid(bufInValidA), .io_bufIn_ready(bufInReadyA), .io_bufIn_payload(bufInBitA),
    .io_bufOut_valid(bufOutValidA), .io_bufOut_ready(bufOutReadyA), .io_bufOut_payload(bufOutWordA),
    .io_bufReset(bufResetA), .io_wordOut_valid(woValidA), .io_wordOut_ready(woReadyA),
    .io_wordOut_payload(woWordA), .io_wordOut_index(woIdxA), .io_wordOut_last(woLastA)
  );

  shift_buffer_ctrl #(.FRAME_WORDS(1), .TIMEOUT_CYCLES(255)) dutB (
    .Core_clk(clk), .Core_reset(rst), .io_start(startB), .io_abort(abortB),
    .io_busy(busyB), .io_done(doneB), .io_error(errorB),
    .io_serIn_valid(serValidB), .io_serIn_ready(serReadyB), .io_serIn_payload(serBitB),
    .io_bufIn_valid(bufInValidB), .io_bufIn_ready(bufInReadyB), .io_bufIn_payload(bufInBitB),
    .io_bufOut_valid(bufOutValidB), .io_bufOut_ready(bufOutReadyB), .io_bufOut_payload(bufOutWordB),
    .io_bufReset(bufResetB), .io_wordOut_valid(woValidB), .io_wordOut_ready(woReadyB),
    .io_wordOut_payload(woWordB), .io_wordOut_index(woIdxB), .io_wordOut_last(woLastB)
  );

  // Behavioural ShiftBuffers: full after 17 bits, valid already on the cycle the 17th bit goes in.
  int unsigned fillA = 0, fillB = 0;
  logic [WW-1:0] srA = '0, srB = '0;
  assign bufInReadyA  = (fillA < WW);
  assign bufOutValidA = (fillA == WW) || ((fillA == WW - 1) && bufInValidA);
  assign bufOutWordA  = srA;
  assign bufInReadyB  = (fillB < WW);
  assign bufOutValidB = (fillB == WW) || ((fillB == WW - 1) && bufInValidB);
  assign bufOutWordB  = srB;

  always @(posedge clk) begin
    if (bufResetA) begin
      fillA <= 0; srA <= '0;
    end else if (bufInValidA && bufInReadyA) begin
      srA <= {srA[WW-2:0], bufInBitA}; fillA <= fillA + 1;
    end else if (bufOutValidA && bufOutReadyA) begin
      fillA <= 0;
    end
    if (bufResetB) begin
      fillB <= 0; srB <= '0;
    end else if (bufInValidB && bufInReadyB) begin
      srB <= {srB[WW-2:0], bufInBitB}; fillB <= fillB + 1;
    end else if (bufOutValidB && bufOutReadyB) begin
      fillB <= 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chkW(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Serial sources and downstream ready driving
  bit txQA[$];
  bit txQB[$];
  bit accA = 1'b0, accB = 1'b0;
  bit serRandA = 1'b0;
  int readyMode = 0;  // 0: ready high, 1: random, 2: ready low

  always begin
    @(posedge clk);
    if (accA && txQA.size() > 0) void'(txQA.pop_front());
    if (accB && txQB.size() > 0) void'(txQB.pop_front());
    #1;
    serValidA = (txQA.size() > 0) && (!serRandA || ($urandom_range(0, 3) != 0));
    serBitA   = (txQA.size() > 0) ? txQA[0] : 1'b0;
    serValidB = (txQB.size() > 0);
    serBitB   = (txQB.size() > 0) ? txQB[0] : 1'b0;
    woReadyA  = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  // Reference model for A: accepted bits, first one MSB, every 17 form an expected word.
  bit modelBits[$];
  logic [WW-1:0] expWordQ[$];
  logic [WW-1:0] monW;
  int wordsSeenA = 0;

  always @(negedge clk) begin
    accA = serValidA && serReadyA;
    accB = serValidB && serReadyB;
    if (rst || (startA && !busyA)) begin
      modelBits.delete();
      expWordQ.delete();
      wordsSeenA = 0;
    end else begin
      if (accA) begin
        modelBits.push_back(accA ? serBitA : 1'b0);
        if (modelBits.size() == WW) begin
          monW = '0;
          foreach (modelBits[i]) monW = {monW[WW-2:0], logic'(modelBits[i])};
          expWordQ.push_back(monW);
          modelBits.delete();
        end
      end
      if (woValidA && woReadyA) begin
        chk1("mon_word_expected", expWordQ.size() > 0, 1'b1);
        if (expWordQ.size() > 0) chkW("mon_payload", 32'(woWordA), 32'(expWordQ.pop_front()));
        chkW("mon_index", 32'(woIdxA), 32'(wordsSeenA));
        chk1("mon_last", woLastA, wordsSeenA == FW_A - 1);
        wordsSeenA++;
      end
    end
  end

  task automatic pushWordA(input logic [WW-1:0] w);
    for (int i = WW - 1; i >= 0; i--) txQA.push_back(w[i]);
  endtask

  task automatic pulseStartA();
    @(posedge clk); #1 startA = 1'b1;
    @(posedge clk); #1 startA = 1'b0;
  endtask

  task automatic pulseAbortA();
    @(posedge clk); #1 abortA = 1'b1;
    @(posedge clk); #1 abortA = 1'b0;
  endtask

  task automatic waitHsA(input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = woValidA && woReadyA;
    end
    chk1(nm, ok, 1'b1);
  endtask

  task automatic waitIdleA(input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busyA;
    end
    chk1(nm, ok, 1'b1);
  endtask

  typedef struct {
    logic [WW-1:0] word;
    logic [1:0]    idx;
    logic          last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int idle;
    bit sawWo;
    bit found;
    int doneAt;
    logic [WW-1:0] w;

    vecs[0] = '{17'h1A5A5, 2'd0, 1'b0};
    vecs[1] = '{17'h1A5A6, 2'd1, 1'b0};
    vecs[2] = '{17'h1A5A7, 2'd2, 1'b0};
    vecs[3] = '{17'h1A5A8, 2'd3, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busyA, 1'b0);
    chk1("rst_done", doneA, 1'b0);
    chk1("rst_error", errorA, 1'b0);
    chk1("rst_wovalid", woValidA, 1'b0);
    chk1("rst_bufreset", bufResetA, 1'b1);
    chk1("rst_serready", serReadyA, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("idle_bufreset", bufResetA, 1'b0);
    chk1("idle_bufoutready", bufOutReadyA, 1'b0);

    // Abort in IDLE is ignored
    pulseAbortA();
    @(negedge clk);
    chk1("idle_abort_busy", busyA, 1'b0);
    chk1("idle_abort_bufreset", bufResetA, 1'b0);
    chk1("idle_abort_error", errorA, 1'b0);

    // Full frame, back-to-back bits, table of expected words
    for (int k = 0; k < 4; k++) pushWordA(vecs[k].word);
    pulseStartA();
    @(negedge clk);
    chk1("clear_bufreset", bufResetA, 1'b1);
    chk1("clear_serready", serReadyA, 1'b0);
    @(negedge clk);
    chk1("shift_serready", serReadyA, 1'b1);
    for (int k = 0; k < 4; k++) begin
      waitHsA(100, $sformatf("t1_hs%0d", k));
      chkW($sformatf("t1_word%0d", k), 32'(woWordA), 32'(vecs[k].word));
      chkW($sformatf("t1_idx%0d", k), 32'(woIdxA), 32'(vecs[k].idx));
      chk1($sformatf("t1_last%0d", k), woLastA, vecs[k].last);
    end
    @(negedge clk);
    chk1("t1_done_pulse", doneA, 1'b1);
    @(negedge clk);
    chk1("t1_done_single", doneA, 1'b0);
    chk1("t1_busy", busyA, 1'b0);
    chk1("t1_error", errorA, 1'b0);

    // Downstream stall in OUT with more bits pending
    readyMode = 2;
    pushWordA(17'h0F0F1);
    pushWordA(17'h15555);
    pulseStartA();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = woValidA;
    end
    chk1("t2_out_reached", found, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chkW("t2_hold_word", 32'(woWordA), 32'(17'h0F0F1));
      chkW("t2_hold_idx", 32'(woIdxA), 32'd0);
      chk1("t2_hold_serready", serReadyA, 1'b0);
      @(negedge clk);
    end
    readyMode = 0;
    waitHsA(20, "t2_hs0");
    waitHsA(100, "t2_hs1");
    chkW("t2_word1", 32'(woWordA), 32'(17'h15555));
    chkW("t2_idx1", 32'(woIdxA), 32'd1);
    pulseAbortA();
    waitIdleA(10, "t2_idle");
    txQA.delete();

    // Stalled serial line -> timeout abort
    for (int i = 0; i < 5; i++) txQA.push_back(1'(i & 1));
    pulseStartA();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = serValidA && serReadyA && (txQA.size() == 1);
    end
    chk1("t3_bits_sent", found, 1'b1);
    idle = 0;
    sawWo = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (woValidA) sawWo = 1'b1;
      if (bufResetA) break;
      idle++;
    end
    chkW("t3_timeout_cycles", 32'(idle), 32'd255);
    chk1("t3_abort_error", errorA, 1'b1);
    @(negedge clk);
    chk1("t3_bufreset_single", bufResetA, 1'b0);
    chk1("t3_busy", busyA, 1'b0);
    chk1("t3_error_sticky", errorA, 1'b1);
    chk1("t3_no_word", sawWo, 1'b0);

    // Abort in the middle of word 2, then restart
    for (int k = 0; k < 4; k++) pushWordA(WW'($urandom));
    pulseStartA();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = (wordsSeenA == 2);
    end
    chk1("t4_two_words", found, 1'b1);
    repeat (8) @(negedge clk);
    pulseAbortA();
    @(negedge clk);
    chk1("t4_bufreset", bufResetA, 1'b1);
    chk1("t4_error", errorA, 1'b1);
    chk1("t4_no_wovalid", woValidA, 1'b0);
    @(negedge clk);
    chk1("t4_idle", busyA, 1'b0);
    txQA.delete();
    pushWordA(17'h1F00F);
    pulseStartA();
    @(negedge clk);
    chk1("t4_error_cleared", errorA, 1'b0);
    waitHsA(100, "t4_hs");
    chkW("t4_idx_restart", 32'(woIdxA), 32'd0);
    chkW("t4_word_restart", 32'(woWordA), 32'(17'h1F00F));
    pulseAbortA();
    waitIdleA(10, "t4_idle2");
    txQA.delete();

    // Reset during SHIFT; start while busy is ignored
    pushWordA(17'h0ACE1);
    pulseStartA();
    repeat (5) @(negedge clk);
    @(posedge clk); #1 startA = 1'b1;
    @(posedge clk); #1 startA = 1'b0;
    @(negedge clk);
    chk1("t5_start_ignored_bufreset", bufResetA, 1'b0);
    chk1("t5_start_ignored_serready", serReadyA, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk1("t5_reset_bufreset", bufResetA, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("t5_busy", busyA, 1'b0);
    chk1("t5_wovalid", woValidA, 1'b0);
    chk1("t5_done", doneA, 1'b0);
    chk1("t5_error", errorA, 1'b0);
    chk1("t5_serready", serReadyA, 1'b0);
    chk1("t5_bufreset_low", bufResetA, 1'b0);
    txQA.delete();

    // Randomised frames with serial gaps and downstream back-pressure
    readyMode = 1;
    serRandA = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) begin
        w = WW'($urandom);
        pushWordA(w);
      end
      pulseStartA();
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
        @(negedge clk);
        found = doneA;
      end
      chk1($sformatf("rand%0d_done", f), found, 1'b1);
      chk1($sformatf("rand%0d_error", f), errorA, 1'b0);
      chkW($sformatf("rand%0d_words", f), 32'(wordsSeenA), 32'(FW_A));
      waitIdleA(10, $sformatf("rand%0d_idle", f));
      txQA.delete();
    end
    readyMode = 0;
    serRandA = 1'b0;

    // FRAME_WORDS=1: single word with last, done 20 cycles after the CLEAR cycle
    w = 17'h0B3C5;
    for (int i = WW - 1; i >= 0; i--) txQB.push_back(w[i]);
    @(posedge clk); #1 startB = 1'b1;
    @(posedge clk); #1 startB = 1'b0;
    doneAt = 0;
    sawWo = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (woValidB) begin
        sawWo = 1'b1;
        chkW("b_word", 32'(woWordB), 32'(17'h0B3C5));
        chkW("b_idx", 32'(woIdxB), 32'd0);
        chk1("b_last", woLastB, 1'b1);
      end
      if (doneB) begin
        doneAt = n;
        break;
      end
    end
    chk1("b_word_seen", sawWo, 1'b1);
    chkW("b_done_cycle", 32'(doneAt), 32'd21);
    chk1("b_error", errorB, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
